ripemd_pad_feeder: RTL and testbench
====================================

// Module: ripemd_pad_feeder
// PURPOSE
// - Collects a short message as a stream of 32-bit little-endian words and appends RIPEMD-160 padding.
// - Builds the single 512-bit block and issues it to ripemd_final (blk -> block, blk_valid -> i_valid).
// - Waits for ripemd_final o_valid before accepting the next message.
// - Sits between the SHA-256 stage and ripemd_final in the Hash160 path; a 32-byte digest is the normal payload.
// PARAMETERS
// - MAX_BYTES  55  largest message accepted; must be <=55 so the message fits one block.
// - WATCHDOG   0   WAIT timeout in cycles; 0 disables the timeout.
// PORTS
// - clk          in   1    clock; all logic on posedge.
// - rst_n        in   1    reset; synchronous, active-low.
// - in_valid     in   1    input beat valid.
// - in_ready     out  1    input beat accepted when in_valid && in_ready.
// - in_data      in   32   message bytes; byte k of the beat is in_data[8k+7:8k].
// - in_bytes     in   3    valid bytes in the beat, 0..4. Must be 4 unless in_last; 0 is legal only with in_last.
// - in_last      in   1    final beat of the message.
// - blk_valid    out  1    one-cycle pulse to ripemd_final i_valid.
// - blk          out  512  padded block; word X[j] = blk[511-32j -: 32]; byte 4j+k of X[j] is at bits [8k+7:8k].
// - core_done    in   1    ripemd_final o_valid; level signal, may stay high between messages.
// - busy         out  1    high in ISSUE and WAIT.
// - err_len      out  1    one-cycle pulse on a length or protocol violation.
// - err_timeout  out  1    one-cycle pulse when the WATCHDOG expires.
// BEHAVIOUR
// - Reset values: state=IDLE, in_ready=1, blk=0, blk_valid=0, busy=0, err_len=0, err_timeout=0, byte_cnt=0, done_q=0.
// - FSM states IDLE, COLLECT, DRAIN, ISSUE, WAIT.
//   - IDLE: the first accepted beat clears blk, writes its bytes and goes to COLLECT, or to ISSUE if in_last.
//   - COLLECT: each beat writes in_bytes bytes at offset byte_cnt, then byte_cnt += in_bytes.
//   - DRAIN: in_ready=1, beats are discarded, in_last returns to IDLE.
//   - ISSUE: blk_valid=1 for exactly one cycle, then WAIT.
//   - WAIT: holds until a rising edge of core_done (core_done && !done_q), then IDLE.
// - Padding is applied in the same cycle the in_last beat is written:
//   - byte[L] = 8'h80, where L is the final byte count.
//   - X[14] = L*8, X[15] = 0.
//   - All other unwritten bytes are 0.
// - Latency: in_last accepted in cycle N gives blk_valid in cycle N+1. blk is stable from N+1 until the next message's first beat.
// - in_ready=0 in ISSUE and WAIT; in_ready=1 in all other states.
// - Rule violations:
//   - Trigger: byte_cnt+in_bytes > MAX_BYTES, or in_bytes != 4 on a non-last beat, or in_bytes > 4.
//   - Response: err_len pulses, no block is issued.
//   - If the violating beat had in_last, go to IDLE; otherwise go to DRAIN.
// - done_q registers core_done every cycle. A stale-high core_done never completes WAIT; it needs a fresh rising edge.
// - Edge cases:
//   - core_done rising in the ISSUE cycle counts and WAIT exits on the next cycle.
//   - WATCHDOG>0: WAIT lasting WATCHDOG cycles pulses err_timeout and returns to IDLE; the counter clears on entering WAIT.
//   - L=0 (in_last with in_bytes=0 as the first beat) gives the empty-message block.
//   - L=MAX_BYTES=55 places 0x80 at byte 55 and is legal.
//   - rst_n low mid-operation restores all reset values on the next edge; a partial message is dropped and no blk_valid is emitted.
// STRUCTURE
// - ripemd_pkg holds:
//   - State enum and constants BLOCK_W=512, WORD_W=32, PAD_BYTE=8'h80, LEN_WORD_IDX=14.
//   - Function byte_pos(idx) mapping a byte index to its blk bit offset.
// - One sub-module, ripemd_byte_merge: combinational; writes up to 4 bytes plus an optional pad byte into the 512-bit buffer at byte_cnt.
// - FSM, counters and error logic stay in this file.
// TESTING
// - Empty message (one beat, in_bytes=0, in_last): X[0]=32'h00000080, others 0.
//   Through ripemd_final, ans = 9c1185a5c5e9fc54612808977ee8f548b2258d31.
// - "abc" (in_data=32'h00636261, in_bytes=3, in_last): X[0]=32'h80636261, X[14]=32'h18.
//   ans = 8eb208f7e05d987a9b044a8e98c6b087f15a0bfc.
// - 32-byte digest as 8 beats: X[8]=32'h00000080, X[14]=32'h100.
//   blk_valid exactly 1 cycle after the 8th beat; in_ready low until the core_done rise.
// - 14 beats of 4 bytes (56 > 55): err_len pulses on beat 14, no blk_valid.
//   Next message "abc" is processed normally.
// - core_done held high from before the message: WAIT persists until it drops and rises again.
//   With WATCHDOG=20 and core_done tied 0, err_timeout pulses 20 cycles after entering WAIT.
// - Reset pulse after 3 beats of a message: no blk_valid; all outputs read reset values; a fresh message completes.

Source files
------------

// File: rtl/ripemd_pkg.sv
// Shared types and constants for the RIPEMD-160 padding feeder.
// byte_pos maps a block byte index to the low bit of that byte within the 512-bit block.
package ripemd_pkg;

  localparam int unsigned BLOCK_W      = 512;
  localparam int unsigned WORD_W       = 32;
  localparam logic [7:0]  PAD_BYTE     = 8'h80;
  localparam int unsigned LEN_WORD_IDX = 14;

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StDrain,
    StIssue,
    StWait
  } state_e;

  // Word j sits at blk[511-32j -: 32], so its low bit is 32*(15-j); byte k adds 8k.
  function automatic logic [8:0] byte_pos(input logic [5:0] idx);
    return {~idx[5:2], idx[1:0], 3'b000};
  endfunction

endpackage

// File: rtl/ripemd_byte_merge.sv
// Combinational merge of up to four message bytes, plus an optional pad byte,
// into the 512-bit block buffer starting at byte offset i_cnt.
module ripemd_byte_merge
  import ripemd_pkg::*;
(
  input  logic [BLOCK_W-1:0] i_blk,
  input  logic [5:0]         i_cnt,
  input  logic [31:0]        i_data,
  input  logic [2:0]         i_nbytes,
  input  logic               i_pad_en,
  output logic [BLOCK_W-1:0] o_blk
);

  always_comb begin
    o_blk = i_blk;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < i_nbytes) begin
        o_blk[byte_pos(i_cnt + 6'(k)) +: 8] = i_data[8*k +: 8];
      end
    end
    // Pad byte lands right after the last written byte.
    if (i_pad_en) begin
      o_blk[byte_pos(i_cnt + 6'(i_nbytes)) +: 8] = PAD_BYTE;
    end
  end

endmodule

// File: rtl/ripemd_pad_feeder.sv
// Collects a short little-endian word stream, applies RIPEMD-160 padding into a single
// 512-bit block, issues it to the compression core and waits for the core's completion.
module ripemd_pad_feeder
  import ripemd_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 55,
  parameter int unsigned WATCHDOG  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  input  logic [2:0]         in_bytes,
  input  logic               in_last,
  output logic               blk_valid,
  output logic [BLOCK_W-1:0] blk,
  input  logic               core_done,
  output logic               busy,
  output logic               err_len,
  output logic               err_timeout
);

  localparam int unsigned WdW = (WATCHDOG > 1) ? $clog2(WATCHDOG) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'(WATCHDOG - 1);

  state_e             r_state, w_state_d;
  logic [BLOCK_W-1:0] r_blk, w_blk_d, w_merge_base, w_merged;
  logic [5:0]         r_byte_cnt, w_byte_cnt_d, w_base_cnt;
  logic [6:0]         w_sum;
  logic [WdW-1:0]     r_wdog, w_wdog_d;
  logic               r_done_q, r_pend, w_pend_d;
  logic               r_err_len, w_err_len_d, r_err_timeout, w_err_timeout_d;
  logic               w_accept, w_viol, w_done_rise;

  assign in_ready    = (r_state == StIdle) || (r_state == StCollect) || (r_state == StDrain);
  assign blk_valid   = (r_state == StIssue);
  assign busy        = (r_state == StIssue) || (r_state == StWait);
  assign blk         = r_blk;
  assign err_len     = r_err_len;
  assign err_timeout = r_err_timeout;

  assign w_accept     = in_valid && in_ready;
  assign w_done_rise  = core_done && !r_done_q;
  assign w_base_cnt   = (r_state == StIdle) ? 6'd0 : r_byte_cnt;
  assign w_merge_base = (r_state == StIdle) ? '0 : r_blk;
  assign w_sum        = {1'b0, w_base_cnt} + {4'b0000, in_bytes};
  assign w_viol       = (in_bytes > 3'd4) || (!in_last && (in_bytes != 3'd4)) ||
                        (w_sum > 7'(MAX_BYTES));

  ripemd_byte_merge u_merge (
    .i_blk    (w_merge_base),
    .i_cnt    (w_base_cnt),
    .i_data   (in_data),
    .i_nbytes (in_bytes),
    .i_pad_en (in_last),
    .o_blk    (w_merged)
  );

  always_comb begin
    w_state_d       = r_state;
    w_blk_d         = r_blk;
    w_byte_cnt_d    = r_byte_cnt;
    w_wdog_d        = r_wdog;
    w_pend_d        = r_pend;
    w_err_len_d     = 1'b0;
    w_err_timeout_d = 1'b0;
    unique case (r_state)
      StIdle, StCollect: begin
        if (w_accept) begin
          if (w_viol) begin
            w_err_len_d  = 1'b1;
            w_byte_cnt_d = 6'd0;
            w_state_d    = in_last ? StIdle : StDrain;
          end else begin
            w_blk_d      = w_merged;
            w_byte_cnt_d = w_sum[5:0];
            if (in_last) begin
              w_blk_d[BLOCK_W-1-WORD_W*LEN_WORD_IDX -: WORD_W] = 32'({w_sum, 3'b000});
              w_blk_d[WORD_W-1:0] = '0;
              w_state_d = StIssue;
            end else begin
              w_state_d = StCollect;
            end
          end
        end
      end
      StDrain: begin
        if (w_accept && in_last) begin
          w_state_d = StIdle;
        end
      end
      StIssue: begin
        // A completion edge seen while issuing still ends the following wait.
        w_pend_d  = w_done_rise;
        w_wdog_d  = '0;
        w_state_d = StWait;
      end
      StWait: begin
        w_wdog_d = r_wdog + 1'b1;
        if (r_pend || w_done_rise) begin
          w_pend_d  = 1'b0;
          w_state_d = StIdle;
        end else if ((WATCHDOG != 0) && (r_wdog == WdLast)) begin
          w_err_timeout_d = 1'b1;
          w_state_d       = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_blk         <= '0;
      r_byte_cnt    <= 6'd0;
      r_wdog        <= '0;
      r_done_q      <= 1'b0;
      r_pend        <= 1'b0;
      r_err_len     <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_blk         <= w_blk_d;
      r_byte_cnt    <= w_byte_cnt_d;
      r_wdog        <= w_wdog_d;
      r_done_q      <= core_done;
      r_pend        <= w_pend_d;
      r_err_len     <= w_err_len_d;
      r_err_timeout <= w_err_timeout_d;
    end
  end

endmodule

// File: tb/tb_ripemd_pad_feeder.sv
// Directed bench for ripemd_pad_feeder: single-beat vector table plus hand-written
// multi-beat, error, completion-edge, watchdog and reset sequences.
module tb_ripemd_pad_feeder;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, in_last, blk_valid, core_done;
  logic         busy, err_len, err_timeout;
  logic [31:0]  in_data;
  logic [2:0]   in_bytes;
  logic [511:0] blk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pulse = 0;

  ripemd_pad_feeder #(
    .MAX_BYTES (55),
    .WATCHDOG  (20)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_bytes    (in_bytes),
    .in_last     (in_last),
    .blk_valid   (blk_valid),
    .blk         (blk),
    .core_done   (core_done),
    .busy        (busy),
    .err_len     (err_len),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (blk_valid) n_pulse <= n_pulse + 1;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [2:0]  nb;
    logic [31:0] x0;
    logic [31:0] x1;
    logic [31:0] x14;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] put_word(input logic [511:0] b, input int j,
                                            input logic [31:0] w);
    logic [511:0] r;
    r = b;
    r[511-32*j -: 32] = w;
    return r;
  endfunction

  function automatic logic [511:0] abc_blk();
    logic [511:0] r;
    r = '0;
    r = put_word(r, 0, 32'h80636261);
    r = put_word(r, 14, 32'h00000018);
    return r;
  endfunction

  task automatic beat(input logic [31:0] d, input logic [2:0] nb, input logic l);
    @(negedge clk);
    chk("in_ready_beat", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_bytes = nb;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called right after the final beat has been accepted.
  task automatic do_block(input string name, input logic [511:0] exp);
    @(negedge clk);
    chk({name, "_valid"}, blk_valid, 1);
    chk({name, "_blk"}, blk, exp);
    chk({name, "_rdy_issue"}, in_ready, 0);
    @(negedge clk);
    chk({name, "_valid_drop"}, blk_valid, 0);
    chk({name, "_busy_wait"}, busy, 1);
    core_done = 1'b1;
    @(negedge clk);
    chk({name, "_busy_done"}, busy, 0);
    chk({name, "_rdy_done"}, in_ready, 1);
    chk({name, "_blk_hold"}, blk, exp);
    core_done = 1'b0;
  endtask

  initial begin
    logic [511:0] exp;
    logic [31:0]  w;
    int           p0, first, cnt_to;

    tbl[0] = '{"empty", 32'h00000000, 3'd0, 32'h00000080, 32'h0, 32'h00000000};
    tbl[1] = '{"abc",   32'h00636261, 3'd3, 32'h80636261, 32'h0, 32'h00000018};
    tbl[2] = '{"a",     32'h00000061, 3'd1, 32'h00008061, 32'h0, 32'h00000008};
    tbl[3] = '{"ab",    32'h00006261, 3'd2, 32'h00806261, 32'h0, 32'h00000010};
    tbl[4] = '{"abcd",  32'h64636261, 3'd4, 32'h64636261, 32'h80, 32'h00000020};
    tbl[5] = '{"junk",  32'hFFFFFF61, 3'd1, 32'h00008061, 32'h0, 32'h00000008};

    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; core_done = 1'b0;
    in_data = '0; in_bytes = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", blk_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_errlen", err_len, 0);
    chk("rst_errto", err_timeout, 0);
    chk("rst_blk", blk, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      exp = '0;
      exp = put_word(exp, 0, tbl[i].x0);
      exp = put_word(exp, 1, tbl[i].x1);
      exp = put_word(exp, 14, tbl[i].x14);
      beat(tbl[i].data, tbl[i].nb, 1'b1);
      do_block(tbl[i].name, exp);
    end

    // 32-byte digest in 8 beats
    exp = '0;
    for (int j = 0; j < 8; j++) begin
      w = {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
      exp = put_word(exp, j, w);
      beat(w, 3'd4, j == 7);
    end
    exp = put_word(exp, 8, 32'h00000080);
    exp = put_word(exp, 14, 32'h00000100);
    @(negedge clk);
    chk("dig_valid", blk_valid, 1);
    chk("dig_blk", blk, exp);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("dig_rdy_low", in_ready, 0);
      chk("dig_valid_low", blk_valid, 0);
    end
    core_done = 1'b1;
    @(negedge clk);
    chk("dig_rdy_back", in_ready, 1);
    core_done = 1'b0;

    // L = 55: pad at byte 55
    exp = '0;
    for (int j = 0; j < 13; j++) begin
      beat(32'hA5A5A5A5, 3'd4, 1'b0);
      exp = put_word(exp, j, 32'hA5A5A5A5);
    end
    beat(32'h00A5A5A5, 3'd3, 1'b1);
    exp = put_word(exp, 13, 32'h80A5A5A5);
    exp = put_word(exp, 14, 32'h000001B8);
    do_block("len55", exp);

    // 56 bytes: error on beat 14, drain, then abc
    p0 = n_pulse;
    for (int j = 0; j < 14; j++) beat(32'h11223344, 3'd4, 1'b0);
    @(negedge clk);
    chk("ovf_errlen", err_len, 1);
    chk("ovf_valid", blk_valid, 0);
    chk("ovf_drain_rdy", in_ready, 1);
    @(negedge clk);
    chk("ovf_errlen_pulse", err_len, 0);
    beat(32'h0, 3'd0, 1'b1);
    repeat (2) @(negedge clk);
    chk("ovf_no_blk", n_pulse, p0);
    beat(32'h00636261, 3'd3, 1'b1);
    do_block("ovf_abc", abc_blk());

    // short non-last beat, drained beats must not leak into the next block
    beat(32'h00001234, 3'd2, 1'b0);
    @(negedge clk);
    chk("short_errlen", err_len, 1);
    beat(32'hDEADBEEF, 3'd4, 1'b0);
    beat(32'h0, 3'd0, 1'b1);
    beat(32'h00636261, 3'd3, 1'b1);
    do_block("short_abc", abc_blk());

    // overflow on an in_last beat returns straight to idle
    p0 = n_pulse;
    for (int j = 0; j < 13; j++) beat(32'h55555555, 3'd4, 1'b0);
    beat(32'h55555555, 3'd4, 1'b1);
    @(negedge clk);
    chk("ovl_errlen", err_len, 1);
    chk("ovl_idle_rdy", in_ready, 1);
    chk("ovl_no_blk", n_pulse, p0);

    // completion edge during the issue cycle
    beat(32'h00636261, 3'd3, 1'b1);
    @(negedge clk);
    chk("iss_valid", blk_valid, 1);
    core_done = 1'b1;
    @(negedge clk);
    chk("iss_busy_wait", busy, 1);
    @(negedge clk);
    chk("iss_busy_exit", busy, 0);
    core_done = 1'b0;

    // stale-high completion must not end the wait
    core_done = 1'b1;
    repeat (2) @(negedge clk);
    beat(32'h00636261, 3'd3, 1'b1);
    @(negedge clk);
    chk("stale_valid", blk_valid, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stale_busy", busy, 1);
    end
    core_done = 1'b0;
    @(negedge clk);
    chk("stale_busy_low", busy, 1);
    core_done = 1'b1;
    @(negedge clk);
    chk("stale_done", busy, 0);
    chk("stale_rdy", in_ready, 1);
    core_done = 1'b0;

    // watchdog: WAIT entered 2 cycles after accept, timeout pulse 20 cycles later
    beat(32'h00636261, 3'd3, 1'b1);
    first = -1;
    cnt_to = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 21) chk("wd_busy_before", busy, 1);
      if (err_timeout) begin
        cnt_to++;
        if (first < 0) first = k;
      end
    end
    chk("wd_cycle", 32'(first), 32'd22);
    chk("wd_pulse_len", cnt_to, 1);
    chk("wd_idle", busy, 0);

    // reset in the middle of a message
    p0 = n_pulse;
    for (int j = 0; j < 3; j++) beat(32'h99999999, 3'd4, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_ready", in_ready, 1);
    chk("mrst_valid", blk_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_errlen", err_len, 0);
    chk("mrst_errto", err_timeout, 0);
    chk("mrst_blk", blk, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_no_blk", n_pulse, p0);
    beat(32'h00636261, 3'd3, 1'b1);
    do_block("mrst_abc", abc_blk());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
